sw_debounce: RTL and testbench

Board-input conditioning block between the raw slide switches and the user logic that consumes them. It does three things for each switch bit independently:
- synchronizes the asynchronous switch level into the clock domain;
- rejects bounce and glitches shorter than a programmable hold time;
- presents a clean level plus single-cycle rise/fall pulses.

Downstream labs read `SW_DB` in place of raw `SW`, so switch-driven logic sees one clean transition per physical flip.

---
 rtl/sw_debounce_if.sv | 7 +
 rtl/sw_debounce.sv | 61 ++++++
 tb/tb_sw_debounce.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sw_debounce_if.sv
// sw_debounce_if: switch-side bundle of the debouncer.
// Raw levels flow in; clean levels and edge pulses flow out.
interface sw_debounce_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] SW, SW_DB, SW_RISE, SW_FALL;
    modport master (output SW, input SW_DB, SW_RISE, SW_FALL);
    modport slave (input SW, output SW_DB, SW_RISE, SW_FALL);
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit synchronizer, hold-time debouncer and registered edge pulses.
// Define SW_DEBOUNCE_EDGE_EN to build the SW_RISE/SW_FALL pulse registers, otherwise they read 0.
module sw_debounce #(
    parameter int WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic CLK,
    input logic CPU_RESETN,
    sw_debounce_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync, db_q, db_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    assign sync = sync_q[SYNC_STAGES-1];
    always_ff @(posedge CLK or negedge CPU_RESETN)
        if (!CPU_RESETN) sync_q <= '0;
        else sync_q <= {sync_q[SYNC_STAGES-2:0], bus.SW};
    always_ff @(posedge CLK or negedge CPU_RESETN)
        if (!CPU_RESETN) begin
            db_q <= '0;
            cnt_q <= '0;
        end else begin
            db_q <= db_d;
            cnt_q <= cnt_d;
        end
    // The counter clears on agreement or on acceptance, so it never passes CNT_MAX
    always_comb begin
        db_d = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = (sync[i] == db_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
            db_d[i] = (sync[i] != db_q[i] && cnt_q[i] == CNT_MAX) ? sync[i] : db_q[i];
        end
    end
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q, fall_q;
    // Pulses register alongside db_q so they line up with the first cycle of the new level
    always_ff @(posedge CLK or negedge CPU_RESETN)
        if (!CPU_RESETN) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= db_d & ~db_q;
            fall_q <= ~db_d & db_q;
        end
    always_comb begin
        bus.SW_DB = db_q;
        bus.SW_RISE = rise_q;
        bus.SW_FALL = fall_q;
    end
`else
    always_comb begin
        bus.SW_DB = db_q;
        bus.SW_RISE = '0;
        bus.SW_FALL = '0;
    end
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed checks of sync latency, glitch/bounce rejection, per-bit independence,
// async reset mid-count and a full 0..255 sweep, with WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_sw_debounce;
`ifdef SW_DEBOUNCE_EDGE_EN
    localparam logic [7:0] EM = 8'hFF;
`else
    localparam logic [7:0] EM = 8'h00;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [7:0] prev;
    sw_debounce_if #(.WIDTH(8)) bus ();
    sw_debounce #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .CLK(clk),
        .CPU_RESETN(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask
    initial begin
        bus.SW = 8'hFF;
        step(3);
        chk("rst_db", bus.SW_DB, 8'h00);
        chk("rst_rise", bus.SW_RISE, 8'h00);
        chk("rst_fall", bus.SW_FALL, 8'h00);
        rst_n = 1'b1;
        step(5);
        chk("t1_db_e5", bus.SW_DB, 8'h00);
        step();
        chk("t1_db_e6", bus.SW_DB, 8'hFF);
        chk("t1_rise_e6", bus.SW_RISE, EM & 8'hFF);
        chk("t1_fall_e6", bus.SW_FALL, 8'h00);
        step();
        chk("t1_rise_e7", bus.SW_RISE, 8'h00);
        chk("t1_db_e7", bus.SW_DB, 8'hFF);
        bus.SW = 8'h00;
        step(6);
        chk("t1_fall_db", bus.SW_DB, 8'h00);
        chk("t1_fall_pulse", bus.SW_FALL, EM & 8'hFF);
        step();
        chk("t1_fall_end", bus.SW_FALL, 8'h00);
        // glitch of 3 cycles is rejected
        bus.SW = 8'h01;
        step(3);
        bus.SW = 8'h00;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_db", bus.SW_DB, 8'h00);
            chk("t2_rise", bus.SW_RISE, 8'h00);
        end
        // bounce 1,0,1,0 then hold 1
        bus.SW = 8'h01; step();
        bus.SW = 8'h00; step();
        bus.SW = 8'h01; step();
        bus.SW = 8'h00; step();
        bus.SW = 8'h01;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t3_db", bus.SW_DB, (k >= 6) ? 8'h01 : 8'h00);
            chk("t3_rise", bus.SW_RISE, (k == 6) ? (EM & 8'h01) : 8'h00);
        end
        bus.SW = 8'h00;
        step(8);
        chk("t3_back", bus.SW_DB, 8'h00);
        // independent bits staggered by two cycles
        bus.SW = 8'h81;
        step(2);
        bus.SW = 8'hC1;
        step(3);
        chk("t4_db_e5", bus.SW_DB, 8'h00);
        step();
        chk("t4_db_e6", bus.SW_DB, 8'h81);
        chk("t4_rise_e6", bus.SW_RISE, EM & 8'h81);
        step();
        chk("t4_db_e7", bus.SW_DB, 8'h81);
        chk("t4_rise_e7", bus.SW_RISE, 8'h00);
        step();
        chk("t4_db_e8", bus.SW_DB, 8'hC1);
        chk("t4_rise_e8", bus.SW_RISE, EM & 8'h40);
        step();
        chk("t4_rise_e9", bus.SW_RISE, 8'h00);
        // reset while bit1 count sits at 2
        bus.SW = 8'hC3;
        step(4);
        chk("t5_db_pre", bus.SW_DB, 8'hC1);
        rst_n = 1'b0;
        #1;
        chk("t5_db_async", bus.SW_DB, 8'h00);
        chk("t5_rise_async", bus.SW_RISE, 8'h00);
        chk("t5_fall_async", bus.SW_FALL, 8'h00);
        step();
        rst_n = 1'b1;
        step(5);
        chk("t5_db_e5", bus.SW_DB, 8'h00);
        step();
        chk("t5_db_e6", bus.SW_DB, 8'hC3);
        chk("t5_rise_e6", bus.SW_RISE, EM & 8'hC3);
        prev = 8'hC3;
        // full sweep
        for (int v = 0; v < 256; v++) begin
            bus.SW = 8'(v);
            step(5);
            chk("t6_db_hold", bus.SW_DB, prev);
            step();
            chk("t6_fall", bus.SW_FALL, EM & prev & ~8'(v));
            chk("t6_rise", bus.SW_RISE, EM & ~prev & 8'(v));
            step();
            chk("t6_fall_end", bus.SW_FALL, 8'h00);
            step(3);
            chk("t6_db", bus.SW_DB, 8'(v));
            prev = 8'(v);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
